// File: rtl/turret_sequencer_if.sv
// ---------------------------------------------------------------------------
// turret_sequencer_if
//
// Bundles every non-clock/reset signal of the turret sequencer so the design
// and its environment connect through one port.
//
// Signal summary (names keep the controller's documented port names):
//   i_Manual                  1 = switches drive the turret, 0 = auto targeting
//   i_Sw_Left / i_Sw_Right    manual X decrement / increment
//   i_Sw_Up / i_Sw_Down       manual Y decrement / increment
//   i_Sw_Fire                 manual fire request (level, rising edge used)
//   i_Tgt_Valid               one-cycle target strobe
//   i_X_Target / i_Y_Target   automatic target coordinates
//   o_X_Cmd / o_Y_Cmd         0 hold, 1 decrement, 2 increment, 3 brake
//   o_Fire_Cmd                0 idle, 1 fire, 2 recoil
//   o_X_Pos / o_Y_Pos         current position counters
//   o_On_Target               auto mode, target latched, both axes on target
//   o_Busy                    fire sequence active
//   dbg_*_state               raw FSM state registers for observation
//
// Handshake: i_Tgt_Valid is a strobe with no ready; whenever it is high at a
// rising clock edge the target pair is captured unconditionally, and a strobe
// held for several cycles simply recaptures each cycle.
//
// Modports: master drives the inputs (environment side), slave is the
// sequencer itself.
// ---------------------------------------------------------------------------
interface turret_sequencer_if #(
   parameter int POS_W = 25
);
   logic             i_Manual;
   logic             i_Sw_Left;
   logic             i_Sw_Right;
   logic             i_Sw_Up;
   logic             i_Sw_Down;
   logic             i_Sw_Fire;
   logic             i_Tgt_Valid;
   logic [POS_W-1:0] i_X_Target;
   logic [POS_W-1:0] i_Y_Target;

   logic [1:0]       o_X_Cmd;
   logic [1:0]       o_Y_Cmd;
   logic [1:0]       o_Fire_Cmd;
   logic [POS_W-1:0] o_X_Pos;
   logic [POS_W-1:0] o_Y_Pos;
   logic             o_On_Target;
   logic             o_Busy;

   logic [1:0]       dbg_x_state;
   logic [1:0]       dbg_y_state;
   logic [1:0]       dbg_fire_state;

   modport master (
      output i_Manual, i_Sw_Left, i_Sw_Right, i_Sw_Up, i_Sw_Down, i_Sw_Fire,
             i_Tgt_Valid, i_X_Target, i_Y_Target,
      input  o_X_Cmd, o_Y_Cmd, o_Fire_Cmd, o_X_Pos, o_Y_Pos, o_On_Target,
             o_Busy, dbg_x_state, dbg_y_state, dbg_fire_state
   );

   modport slave (
      input  i_Manual, i_Sw_Left, i_Sw_Right, i_Sw_Up, i_Sw_Down, i_Sw_Fire,
             i_Tgt_Valid, i_X_Target, i_Y_Target,
      output o_X_Cmd, o_Y_Cmd, o_Fire_Cmd, o_X_Pos, o_Y_Pos, o_On_Target,
             o_Busy, dbg_x_state, dbg_y_state, dbg_fire_state
   );
endinterface

// File: rtl/turret_sequencer.sv
// ---------------------------------------------------------------------------
// turret_sequencer
//
// Central controller for a two-axis servo turret plus firing servo. Chooses
// between manual switches and automatic target coordinates (i_Manual), keeps
// bounded X/Y position counters, emits per-axis direction codes, and runs the
// fire -> recoil timing sequence, freezing both axes while it runs.
//
// Ports:
//   i_Clk    system clock, all state on its rising edge
//   i_Rst_L  asynchronous active-low reset
//   bus      turret_sequencer_if.slave (switches, target, commands, status)
//
// Optional build macro:
//   TURRET_SAFE_FIRE_EN  when defined, a manual fire edge is accepted only
//                        while both axes are in HOLD; otherwise any manual
//                        fire edge seen while idle starts a sequence.
//
// All command/status outputs decode registers only, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module turret_sequencer #(
   parameter int POS_MAX       = 22727272,
   parameter int POS_W         = 25,
   parameter int FIRE_CYCLES   = 250000000,
   parameter int RECOIL_CYCLES = 100000000,
   parameter int CNT_W         = 28
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   turret_sequencer_if.slave bus
);

   // State encodings equal the output command codes, so decode is direct.
   typedef enum logic [1:0] {
      AX_HOLD  = 2'd0,
      AX_DEC   = 2'd1,
      AX_INC   = 2'd2,
      AX_BRAKE = 2'd3
   } axis_state_t;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_FIRE   = 2'd1,
      FS_RECOIL = 2'd2
   } fire_state_t;

   localparam logic [POS_W-1:0] POS_LIMIT   = POS_W'(POS_MAX);
   localparam logic [CNT_W-1:0] FIRE_LAST   = CNT_W'(FIRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOIL_LAST = CNT_W'(RECOIL_CYCLES - 1);

   axis_state_t      x_state, x_state_nx;
   axis_state_t      y_state, y_state_nx;
   fire_state_t      fire_state, fire_state_nx;

   logic [POS_W-1:0] x_pos, y_pos;
   logic [POS_W-1:0] x_tgt, y_tgt;
   logic [POS_W-1:0] x_tgt_clamped, y_tgt_clamped;
   logic             tgt_latched;
   logic             fired;
   logic             fire_sw_q;
   logic             manual_q;
   logic [CNT_W-1:0] timer;

   logic             busy;
   logic             mode_chg;
   logic             fire_edge;
   logic             manual_fire_ok;
   logic             fire_start;
   logic             on_target;
   logic             x_dec_ok, x_inc_ok, y_dec_ok, y_inc_ok;

   // ------------------------------------------------------------------
   // Derived conditions
   // ------------------------------------------------------------------
   assign busy      = (fire_state != FS_IDLE);
   assign mode_chg  = (bus.i_Manual != manual_q);
   assign fire_edge = bus.i_Sw_Fire & ~fire_sw_q;

   // Registered mode copy keeps o_On_Target free of an input path.
   assign on_target = ~manual_q & tgt_latched &
                      (x_pos == x_tgt) & (y_pos == y_tgt);

   assign x_tgt_clamped = (bus.i_X_Target > POS_LIMIT) ? POS_LIMIT : bus.i_X_Target;
   assign y_tgt_clamped = (bus.i_Y_Target > POS_LIMIT) ? POS_LIMIT : bus.i_Y_Target;

`ifdef TURRET_SAFE_FIRE_EN
   assign manual_fire_ok = fire_edge & (x_state == AX_HOLD) & (y_state == AX_HOLD);
`else
   assign manual_fire_ok = fire_edge;
`endif

   assign fire_start = bus.i_Manual ? manual_fire_ok : (on_target & ~fired);

   // Per-axis motion wishes. An active fire sequence forces them all false.
   // In auto mode the target is already clamped, so pos<tgt implies
   // pos<POS_MAX and the counter cannot run past its bound.
   always_comb begin : axis_entry
      x_dec_ok = 1'b0;
      x_inc_ok = 1'b0;
      y_dec_ok = 1'b0;
      y_inc_ok = 1'b0;
      if (!busy) begin
         if (bus.i_Manual) begin
            x_dec_ok = bus.i_Sw_Left  & ~bus.i_Sw_Right & (x_pos != '0);
            x_inc_ok = bus.i_Sw_Right & ~bus.i_Sw_Left  & (x_pos < POS_LIMIT);
            y_dec_ok = bus.i_Sw_Up    & ~bus.i_Sw_Down  & (y_pos != '0);
            y_inc_ok = bus.i_Sw_Down  & ~bus.i_Sw_Up    & (y_pos < POS_LIMIT);
         end else if (tgt_latched) begin
            x_dec_ok = (x_pos > x_tgt);
            x_inc_ok = (x_pos < x_tgt);
            y_dec_ok = (y_pos > y_tgt);
            y_inc_ok = (y_pos < y_tgt);
         end
      end
   end

   // A moving axis keeps moving only while its own condition holds and the
   // mode is unchanged; anything else goes through a one-cycle BRAKE, which
   // also guarantees every reversal passes through BRAKE and HOLD.
   function automatic axis_state_t axis_next(input axis_state_t cur,
                                             input logic        dec_ok,
                                             input logic        inc_ok,
                                             input logic        chg);
      axis_state_t nx;
      nx = AX_HOLD;
      case (cur)
         AX_HOLD: begin
            if (dec_ok)      nx = AX_DEC;
            else if (inc_ok) nx = AX_INC;
            else             nx = AX_HOLD;
         end
         AX_DEC:   nx = (dec_ok && !chg) ? AX_DEC : AX_BRAKE;
         AX_INC:   nx = (inc_ok && !chg) ? AX_INC : AX_BRAKE;
         AX_BRAKE: nx = AX_HOLD;
         default:  nx = AX_HOLD;
      endcase
      return nx;
   endfunction

   // ------------------------------------------------------------------
   // FSM state registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin : state_reg
      if (!i_Rst_L) begin
         x_state    <= AX_HOLD;
         y_state    <= AX_HOLD;
         fire_state <= FS_IDLE;
      end else begin
         x_state    <= x_state_nx;
         y_state    <= y_state_nx;
         fire_state <= fire_state_nx;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin : axis_next_state
      x_state_nx = axis_next(x_state, x_dec_ok, x_inc_ok, mode_chg);
      y_state_nx = axis_next(y_state, y_dec_ok, y_inc_ok, mode_chg);
   end

   always_comb begin : fire_next_state
      fire_state_nx = fire_state;
      case (fire_state)
         FS_IDLE:   if (fire_start)            fire_state_nx = FS_FIRE;
         FS_FIRE:   if (timer == FIRE_LAST)    fire_state_nx = FS_RECOIL;
         FS_RECOIL: if (timer == RECOIL_LAST)  fire_state_nx = FS_IDLE;
         default:                              fire_state_nx = FS_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers: positions, timer, target latch, edge/mode copies
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin : datapath_reg
      if (!i_Rst_L) begin
         x_pos       <= '0;
         y_pos       <= '0;
         x_tgt       <= '0;
         y_tgt       <= '0;
         tgt_latched <= 1'b0;
         fired       <= 1'b0;
         fire_sw_q   <= 1'b0;
         manual_q    <= 1'b0;
         timer       <= '0;
      end else begin
         fire_sw_q <= bus.i_Sw_Fire;
         manual_q  <= bus.i_Manual;

         // A step happens only on an edge where the axis both is and stays in
         // its motion state, so the counter stops exactly at its target or
         // bound: the first step lands one edge after the command appears.
         if (x_state == AX_DEC && x_state_nx == AX_DEC) x_pos <= x_pos - POS_W'(1);
         if (x_state == AX_INC && x_state_nx == AX_INC) x_pos <= x_pos + POS_W'(1);
         if (y_state == AX_DEC && y_state_nx == AX_DEC) y_pos <= y_pos - POS_W'(1);
         if (y_state == AX_INC && y_state_nx == AX_INC) y_pos <= y_pos + POS_W'(1);

         // A new target re-arms automatic fire even if it arrives on the
         // same edge as an automatic fire start.
         if (bus.i_Tgt_Valid) begin
            x_tgt       <= x_tgt_clamped;
            y_tgt       <= y_tgt_clamped;
            tgt_latched <= 1'b1;
            fired       <= 1'b0;
         end else if (fire_state == FS_IDLE && fire_start && !bus.i_Manual) begin
            fired <= 1'b1;
         end

         // Timer restarts on every state change and counts within a state.
         if (fire_state_nx != fire_state) timer <= '0;
         else if (fire_state != FS_IDLE)  timer <= timer + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Output decode (registers only)
   // ------------------------------------------------------------------
   always_comb begin : output_decode
      bus.o_X_Cmd        = x_state;
      bus.o_Y_Cmd        = y_state;
      bus.o_Fire_Cmd     = fire_state;
      bus.o_X_Pos        = x_pos;
      bus.o_Y_Pos        = y_pos;
      bus.o_On_Target    = on_target;
      bus.o_Busy         = busy;
      bus.dbg_x_state    = x_state;
      bus.dbg_y_state    = y_state;
      bus.dbg_fire_state = fire_state;
   end

endmodule

// File: tb/tb_turret_sequencer.sv
// ---------------------------------------------------------------------------
// tb_turret_sequencer
//
// Self-checking bench for turret_sequencer with small parameters
// (POS_MAX=10, FIRE_CYCLES=4, RECOIL_CYCLES=3). A behavioural model tracks
// each axis as a signed direction plus a pending brake and the fire sequence
// as a countdown of remaining cycles; every clock its view is compared with
// the design. A vector table covers switch conflict and reversal, and
// directed sequences cover bounds, auto seek, clamping, retargeting, held
// fire and asynchronous reset; a randomized phase follows.
// Honours TURRET_SAFE_FIRE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_turret_sequencer;

   localparam int POS_W         = 25;
   localparam int POS_MAX       = 10;
   localparam int FIRE_CYCLES   = 4;
   localparam int RECOIL_CYCLES = 3;
   localparam int CNT_W         = 28;
   localparam int SEQ_LEN       = FIRE_CYCLES + RECOIL_CYCLES;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   turret_sequencer_if #(.POS_W(POS_W)) bus();

   turret_sequencer #(
      .POS_MAX      (POS_MAX),
      .POS_W        (POS_W),
      .FIRE_CYCLES  (FIRE_CYCLES),
      .RECOIL_CYCLES(RECOIL_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .i_Clk  (clk),
      .i_Rst_L(rst_n),
      .bus    (bus)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] exp_q[$];

   // Model: output codes m_xc/m_yc, positions, targets, fire countdown.
   int m_xc, m_yc, m_xp, m_yp, m_xt, m_yt;
   int m_latched, m_fired, m_left, m_sw_q, m_man_q;

   typedef struct packed {
      logic       man;
      logic       left;
      logic       right;
      logic [1:0] exp_cmd;
      logic [3:0] exp_pos;
   } vec_t;
   vec_t vecs[14];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_pos(input int v);
      return (v > POS_MAX) ? POS_MAX : v;
   endfunction

   // Desired direction of one axis: -1, 0 or +1.
   function automatic int axis_want(input int man, input int dsw, input int isw,
                                    input int pos, input int tgt, input int busy,
                                    input int latched);
      if (busy != 0) return 0;
      if (man != 0) begin
         if (isw != 0 && dsw == 0 && pos < POS_MAX) return 1;
         if (dsw != 0 && isw == 0 && pos > 0) return -1;
         return 0;
      end
      if (latched == 0) return 0;
      if (tgt > pos) return 1;
      if (tgt < pos) return -1;
      return 0;
   endfunction

   task automatic axis_step(input int code_i, input int pos_i, input int want,
                            input int chg, output int code_o, output int pos_o);
      int dir;
      dir    = (code_i == 1) ? -1 : (code_i == 2) ? 1 : 0;
      code_o = code_i;
      pos_o  = pos_i;
      if (code_i == 3) begin
         code_o = 0;
      end else if (dir != 0) begin
         if (want == dir && chg == 0) pos_o = pos_i + dir;
         else                         code_o = 3;
      end else begin
         code_o = (want == 1) ? 2 : (want == -1) ? 1 : 0;
      end
   endtask

   task automatic model_reset();
      m_xc = 0; m_yc = 0; m_xp = 0; m_yp = 0; m_xt = 0; m_yt = 0;
      m_latched = 0; m_fired = 0; m_left = 0; m_sw_q = 0; m_man_q = 0;
   endtask

   // Advance the model by one clock using the inputs present before the edge.
   task automatic model_step();
      int man, busy, chg, wx, wy, safe_ok, on_pre, start, nxc, nxp, nyc, nyp;
      man  = int'(bus.i_Manual);
      busy = (m_left > 0) ? 1 : 0;
      chg  = (man != m_man_q) ? 1 : 0;
      wx = axis_want(man, int'(bus.i_Sw_Left), int'(bus.i_Sw_Right),
                     m_xp, m_xt, busy, m_latched);
      wy = axis_want(man, int'(bus.i_Sw_Up), int'(bus.i_Sw_Down),
                     m_yp, m_yt, busy, m_latched);
`ifdef TURRET_SAFE_FIRE_EN
      safe_ok = (m_xc == 0 && m_yc == 0) ? 1 : 0;
`else
      safe_ok = 1;
`endif
      on_pre = (m_man_q == 0 && m_latched != 0 && m_xp == m_xt && m_yp == m_yt) ? 1 : 0;
      if (man != 0) start = (bus.i_Sw_Fire && m_sw_q == 0 && safe_ok != 0) ? 1 : 0;
      else          start = (on_pre != 0 && m_fired == 0) ? 1 : 0;
      if (m_left != 0) start = 0;

      axis_step(m_xc, m_xp, wx, chg, nxc, nxp);
      axis_step(m_yc, m_yp, wy, chg, nyc, nyp);
      m_xc = nxc; m_xp = nxp; m_yc = nyc; m_yp = nyp;

      if (m_left > 0)      m_left = m_left - 1;
      else if (start != 0) m_left = SEQ_LEN;

      if (start != 0 && man == 0) m_fired = 1;
      if (bus.i_Tgt_Valid) begin
         m_xt = clamp_pos(int'(bus.i_X_Target));
         m_yt = clamp_pos(int'(bus.i_Y_Target));
         m_latched = 1;
         m_fired   = 0;
      end
      m_sw_q  = int'(bus.i_Sw_Fire);
      m_man_q = man;
   endtask

   task automatic compare_model();
      int exp_on, exp_fire;
      exp_on   = (m_man_q == 0 && m_latched != 0 && m_xp == m_xt && m_yp == m_yt) ? 1 : 0;
      exp_fire = (m_left == 0) ? 0 : (m_left > RECOIL_CYCLES) ? 1 : 2;
      check("x_cmd",     int'(bus.o_X_Cmd),     m_xc);
      check("y_cmd",     int'(bus.o_Y_Cmd),     m_yc);
      check("x_pos",     int'(bus.o_X_Pos),     m_xp);
      check("y_pos",     int'(bus.o_Y_Pos),     m_yp);
      check("fire_cmd",  int'(bus.o_Fire_Cmd),  exp_fire);
      check("busy",      int'(bus.o_Busy),      (m_left > 0) ? 1 : 0);
      check("on_target", int'(bus.o_On_Target), exp_on);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle(input logic man);
      bus.i_Manual    = man;
      bus.i_Sw_Left   = 1'b0;
      bus.i_Sw_Right  = 1'b0;
      bus.i_Sw_Up     = 1'b0;
      bus.i_Sw_Down   = 1'b0;
      bus.i_Sw_Fire   = 1'b0;
      bus.i_Tgt_Valid = 1'b0;
      bus.i_X_Target  = '0;
      bus.i_Y_Target  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle(1'b0);
      model_reset();
      @(negedge clk);
      compare_model();
      check("reset_fire_cmd", int'(bus.o_Fire_Cmd), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic strobe_target(input int x, input int y);
      bus.i_Tgt_Valid = 1'b1;
      bus.i_X_Target  = POS_W'(x);
      bus.i_Y_Target  = POS_W'(y);
      tick();
      bus.i_Tgt_Valid = 1'b0;
   endtask

   task automatic wait_fire(input string name, input int limit);
      int found;
      found = 0;
      for (int i = 0; i < limit && found == 0; i++) begin
         tick();
         if (bus.o_Fire_Cmd == 2'd1) found = 1;
      end
      check(name, found, 1);
   endtask

   // ---------------- test ----------------
   initial begin
      int seq_cnt;
      int prev_busy;
      int busy_seen;

      // Switch conflict then reversal, starting at position 0.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 4'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd0, 4'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'd1};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'd2};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd3, 4'd2};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd2};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 4'd2};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd1, 4'd1};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd1, 4'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd3, 4'd0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0};

      drive_idle(1'b0);
      model_reset();
      do_reset();

      for (int i = 0; i < 14; i++) begin
         bus.i_Manual   = vecs[i].man;
         bus.i_Sw_Left  = vecs[i].left;
         bus.i_Sw_Right = vecs[i].right;
         tick();
         check("vec_x_cmd", int'(bus.o_X_Cmd), int'(vecs[i].exp_cmd));
         check("vec_x_pos", int'(bus.o_X_Pos), int'(vecs[i].exp_pos));
      end

      // Manual upper bound: hold right from 0 for 20 cycles.
      bus.i_Sw_Right = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 11) check("bound_brake_cmd", int'(bus.o_X_Cmd), 3);
      end
      check("bound_pos", int'(bus.o_X_Pos), POS_MAX);
      check("bound_hold_cmd", int'(bus.o_X_Cmd), 0);
      bus.i_Sw_Right = 1'b0;

      // Auto seek to (7,3), one fire, no refire.
      do_reset();
      bus.i_Manual = 1'b0;
      strobe_target(7, 3);
      wait_fire("auto_fire_start", 40);
      check("auto_x_pos", int'(bus.o_X_Pos), 7);
      check("auto_y_pos", int'(bus.o_Y_Pos), 3);
      check("auto_on_target", int'(bus.o_On_Target), 1);
      for (int i = 1; i < FIRE_CYCLES; i++) exp_q.push_back(2'd1);
      for (int i = 0; i < RECOIL_CYCLES; i++) exp_q.push_back(2'd2);
      exp_q.push_back(2'd0);
      while (exp_q.size() > 0) begin
         tick();
         check("auto_fire_seq", int'(bus.o_Fire_Cmd), int'(exp_q.pop_front()));
      end
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.o_Busy) busy_seen++;
      end
      check("auto_no_refire", busy_seen, 0);

      // Clamp, then retarget mid-motion with reversal.
      strobe_target(50, 3);
      wait_fire("clamp_fire_start", 60);
      check("clamp_x_pos", int'(bus.o_X_Pos), POS_MAX);
      for (int i = 0; i < 10; i++) tick();
      strobe_target(0, 0);
      for (int i = 0; i < 4; i++) tick();
      strobe_target(9, 2);
      wait_fire("retarget_fire_start", 60);
      check("retarget_x_pos", int'(bus.o_X_Pos), 9);
      check("retarget_y_pos", int'(bus.o_Y_Pos), 2);

      // Manual fire held while X is moving.
      do_reset();
      bus.i_Manual   = 1'b1;
      bus.i_Sw_Right = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus.i_Sw_Fire = 1'b1;
      seq_cnt   = 0;
      prev_busy = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.o_Busy && prev_busy == 0) seq_cnt++;
         prev_busy = int'(bus.o_Busy);
      end
`ifdef TURRET_SAFE_FIRE_EN
      check("held_fire_sequences", seq_cnt, 0);
`else
      check("held_fire_sequences", seq_cnt, 1);
`endif

      // Asynchronous reset in the middle of FIRE.
      drive_idle(1'b1);
      for (int i = 0; i < 3; i++) tick();
      bus.i_Sw_Fire = 1'b1;
      tick();
      check("rst_fire_started", int'(bus.o_Fire_Cmd), 1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_async_fire_cmd", int'(bus.o_Fire_Cmd), 0);
      check("rst_async_busy",     int'(bus.o_Busy),     0);
      check("rst_async_x_pos",    int'(bus.o_X_Pos),    0);
      check("rst_async_x_cmd",    int'(bus.o_X_Cmd),    0);
      bus.i_Sw_Fire = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_release_busy", int'(bus.o_Busy), 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 29) == 0) bus.i_Manual = ~bus.i_Manual;
         if ($urandom_range(0, 3) == 0) bus.i_Sw_Left  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bus.i_Sw_Right = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bus.i_Sw_Up    = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bus.i_Sw_Down  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) bus.i_Sw_Fire  = ~bus.i_Sw_Fire;
         bus.i_Tgt_Valid = ($urandom_range(0, 19) == 0);
         if (bus.i_Tgt_Valid) begin
            bus.i_X_Target = POS_W'($urandom_range(0, 15));
            bus.i_Y_Target = POS_W'($urandom_range(0, 15));
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
